// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding, default way width and memory-latency bounds for the cache miss controller.
// Pure declarations: no logic, no latency, no flow control.
package cache_ctrl_pkg;

  localparam int WAY_W       = 2;
  localparam int CNT_W       = 3;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOOKUP = 3'd1;
  localparam state_t S_WB     = 3'd2;
  localparam state_t S_REFILL = 3'd3;
  localparam state_t S_FILL   = 3'd4;
  localparam state_t S_RESP   = 3'd5;

  // An out-of-range MEM_LAT is pinned to the nearest legal value so REFILL always terminates.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    if (lat < MEM_LAT_MIN) return CNT_W'(MEM_LAT_MIN);
    if (lat > MEM_LAT_MAX) return CNT_W'(MEM_LAT_MAX);
    return CNT_W'(lat);
  endfunction

endpackage

// File: rtl/cache_ctrl_lat_cnt.sv
// Loadable down-counter: o_done pulses on the last enabled cycle of a loaded count.
// Latency: o_done is high in the i_val-th enabled cycle after i_load. No backpressure.
module cache_ctrl_lat_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = i_en && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/cache_miss_controller.sv
// Sequences CPU accesses: lookup, dirty writeback, refill and array update; optional stats via CACHE_CTRL_STATS_EN.
// Latency: hit 2, clean miss 3+MEM_LAT, dirty miss 4+MEM_LAT cycles; one request in flight, req_ready only in IDLE.
module cache_miss_controller #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 5,
  parameter int WAY_W   = cache_ctrl_pkg::WAY_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] lookup_addr,
  input  logic              lookup_hit,
  input  logic [WAY_W-1:0]  lookup_way,
  input  logic [DATA_W-1:0] lookup_data,
  input  logic [WAY_W-1:0]  victim_way,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [DATA_W-1:0] victim_data,
  output logic              cache_we,
  output logic [WAY_W-1:0]  cache_way,
  output logic [ADDR_W-1:0] cache_tag,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              cache_dirty,
  output logic              lru_touch,
  output logic [WAY_W-1:0]  lru_way,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef CACHE_CTRL_STATS_EN
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
  output logic [15:0]       wb_count,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  import cache_ctrl_pkg::*;

  state_t              r_state;
  state_t              w_next;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_hit;
  logic [DATA_W-1:0]   r_rdata;
  logic [WAY_W-1:0]    r_vway;
  logic [ADDR_W-1:0]   r_vaddr;
  logic [DATA_W-1:0]   r_vdata;
  logic                w_vic_dirty;
  logic                w_cnt_load;
  logic                w_cnt_done;

  // An invalid victim never needs writing back, whatever its dirty bit says.
  assign w_vic_dirty = victim_valid && victim_dirty;
  assign w_cnt_load  = (r_state != S_REFILL) && (w_next == S_REFILL);

  cache_ctrl_lat_cnt #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_cnt_load),
    .i_val   (lat_load(MEM_LAT)),
    .i_en    (r_state == S_REFILL),
    .o_done  (w_cnt_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (lookup_hit)       w_next = S_RESP;
        else if (w_vic_dirty) w_next = S_WB;
        else                  w_next = S_REFILL;
      end
      S_WB:     w_next = S_REFILL;
      S_REFILL: if (w_cnt_done) w_next = S_FILL;
      S_FILL:   w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_hit    = 1'b0;
    resp_rdata  = '0;
    lookup_addr = '0;
    cache_we    = 1'b0;
    cache_way   = '0;
    cache_tag   = '0;
    cache_wdata = '0;
    cache_dirty = 1'b0;
    lru_touch   = 1'b0;
    lru_way     = '0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (r_state)
      S_IDLE:   req_ready = 1'b1;
      S_LOOKUP: begin
        lookup_addr = r_addr;
        if (lookup_hit) begin
          lru_touch = 1'b1;
          lru_way   = lookup_way;
          if (r_write) begin
            cache_we    = 1'b1;
            cache_way   = lookup_way;
            cache_tag   = r_addr;
            cache_wdata = r_wdata;
            cache_dirty = 1'b1;
          end
        end
      end
      S_WB: begin
        mem_we    = 1'b1;
        mem_addr  = r_vaddr;
        mem_wdata = r_vdata;
      end
      S_REFILL: mem_addr = r_addr;
      S_FILL: begin
        // Write-allocate: a write miss installs its own data and drops the refill word.
        cache_we    = 1'b1;
        cache_way   = r_vway;
        cache_tag   = r_addr;
        cache_wdata = r_write ? r_wdata : mem_rdata;
        cache_dirty = r_write;
        lru_touch   = 1'b1;
        lru_way     = r_vway;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_hit   = r_hit;
        resp_rdata = r_write ? '0 : r_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hit   <= 1'b0;
      r_rdata <= '0;
      r_vway  <= '0;
      r_vaddr <= '0;
      r_vdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_write <= req_write;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_hit   <= 1'b0;
          r_rdata <= '0;
        end
        S_LOOKUP: begin
          r_hit   <= lookup_hit;
          if (lookup_hit && !r_write) r_rdata <= lookup_data;
          r_vway  <= victim_way;
          r_vaddr <= victim_addr;
          r_vdata <= victim_data;
        end
        S_FILL: if (!r_write) r_rdata <= mem_rdata;
        default: ;
      endcase
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;
  logic [15:0] r_wb_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (r_state == S_RESP && r_hit && r_hit_cnt != 16'hFFFF)    r_hit_cnt  <= r_hit_cnt + 16'd1;
      if (r_state == S_RESP && !r_hit && r_miss_cnt != 16'hFFFF)  r_miss_cnt <= r_miss_cnt + 16'd1;
      if (r_state == S_WB && r_wb_cnt != 16'hFFFF)                r_wb_cnt   <= r_wb_cnt + 16'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
  assign wb_count   = r_wb_cnt;
`endif

endmodule
